sdram_chip_model: RTL and testbench
===================================

// Module: sdram_chip_model
// PURPOSE
//  Responder side of the 16-bit SDR SDRAM pin interface: decodes CS/RAS/CAS/WE commands and keeps per-bank row state.
//  Serves single-beat reads/writes from an internal 16-bit word store, honouring CAS latency and DQM byte masks.
//  Checks protocol and timing, and flags violations.
//  Sits opposite the SDRAM controller: in simulation benches, and as a BRAM-backed stand-in on boards without SDRAM.
// PARAMETERS
//  ADDR_W  16  word-store depth = 2**ADDR_W x 16b; store index = low ADDR_W bits of {BA,row,col}
//  TRCD    2   min cycles from ACTIVE to READ/WRITE on the same bank
//  TRP     2   min cycles from PRECHARGE (explicit or auto) to ACTIVE on the same bank
// PORTS
//  clk          in     1   sole clock; all pins sampled on rising edge
//  init         in     1   reset, asynchronous, active-high
//  SDRAM_CKE    in     1   0: command sampled as NOP
//  SDRAM_nCS    in     1   command bits {nCS,nRAS,nCAS,nWE}
//  SDRAM_nRAS   in     1
//  SDRAM_nCAS   in     1
//  SDRAM_nWE    in     1
//  SDRAM_BA     in     2   bank
//  SDRAM_A      in     13  row (ACTIVE) / {A10=auto-precharge, col=A[8:0]} (READ/WRITE) / mode (LOAD_MODE)
//  SDRAM_DQML   in     1   1 = mask low byte
//  SDRAM_DQMH   in     1   1 = mask high byte
//  SDRAM_DQ     inout  16  driven only in read data slot, else Z
//  ready        out    1   mode register loaded, normal commands accepted
//  err          out    1   sticky; set on first violation
//  err_code     out    3   code of first violation (see below)
//  refresh_cnt  out    16  AUTO_REFRESH count, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (init=1, async): SDRAM_DQ=Z, ready=0, err=0, err_code=0, refresh_cnt=0.
//   Also closes all banks and clears mode, timers and the read pipeline; word store is NOT cleared.
//  Commands: 1111/0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO_REFRESH, 0000 LOAD_MODE.
//   0110 BURST_TERMINATE is a NOP.
//  Bank FSM, per bank: IDLE -ACTIVE-> OPEN(row latched) -PRECHARGE or auto-precharge-> IDLE.
//   Each bank has a timer: TRCD starts at ACTIVE; TRP starts at PRECHARGE or at a R/W edge with A10=1.
//  PRECHARGE: A10=1 closes all banks, else bank BA; precharging an idle bank is legal.
//  LOAD_MODE: only with all banks IDLE; latches CL=A[6:4] and burst length=A[2:0].
//   CL must be 2 or 3 and burst length 0, else code 3; ready=1 only on a valid load.
//  Before ready: ACTIVE/READ/WRITE -> code 4, command ignored.
//  WRITE at edge k: DQ sampled at edge k.
//   Byte lanes with DQM=0 are written; DQM=11 writes nothing.
//   A READ to the same word at edge k+1 returns the new data.
//  READ at edge k: word fetched from the store; DQ driven right after edge k+CL-1, released (Z) right after edge k+CL.
//   The controller samples at edge k+CL.
//   Reads at back-to-back edges pipeline; each occupies its own slot.
//   DQM at READ is ignored (full word returned).
//  Violations: the violating command is ignored and no bank state changes.
//   1 = ACTIVE on an OPEN bank, R/W on an IDLE bank, AUTO_REFRESH or LOAD_MODE with any bank OPEN.
//   2 = TRCD or TRP violated.
//   5 = WRITE sampled while a read slot is driving DQ; no write occurs and DQ stays driven.
//  If several violations occur on one edge, the lowest code wins; err_code then holds until init.
//  CKE=0: command ignored, but the in-flight read pipeline still completes.
//  init asserted mid-read: DQ goes Z asynchronously; pending data is discarded.
// TESTING
//  1. PRECHARGE A10=1, 8x AUTO_REFRESH, LOAD_MODE A=0x220 -> ready=1, refresh_cnt=8, err=0.
//  2. ACTIVE BA=1 row 0x012; WRITE at +2, col 0x005, A10=1, DQ=0xA55A, DQMH=1 DQML=0.
//     Then ACTIVE at +2, READ at +2 -> DQ=0x005A at read edge+2, Z one cycle later.
//  3. LOAD_MODE CL=3; READ of 0x1234 at edge k, plus a second READ (other bank) at k+1.
//     -> 0x1234 valid at k+3, second word at k+4, Z at k+5; no err.
//  4. READ 1 cycle after ACTIVE -> err=1, err_code=2, DQ stays Z. Later ACTIVE on the still-open bank -> err_code stays 2.
//  5. From reset: ACTIVE before LOAD_MODE -> err_code=4. LOAD_MODE A=0x021 -> ready stays 0.
//  6. init pulse at k+1 after READ at k (CL=2) -> DQ Z at once, ready=0, refresh_cnt=0.
//     After re-init, READ of the same word returns the pre-reset data.

Source files
------------

// File: rtl/sdram_chip_model_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdram_chip_model_if                                                |
// | Command/address/mask pins between an SDRAM controller and the chip |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface sdram_chip_model_if;
    logic        SDRAM_CKE;
    logic        SDRAM_nCS;
    logic        SDRAM_nRAS;
    logic        SDRAM_nCAS;
    logic        SDRAM_nWE;
    logic [1:0]  SDRAM_BA;
    logic [12:0] SDRAM_A;
    logic        SDRAM_DQML;
    logic        SDRAM_DQMH;

    modport master (
        output SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
        output SDRAM_BA, SDRAM_A, SDRAM_DQML, SDRAM_DQMH
    );

    modport slave (
        input SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
        input SDRAM_BA, SDRAM_A, SDRAM_DQML, SDRAM_DQMH
    );
endinterface
`default_nettype wire

// File: rtl/sdram_chip_model.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdram_chip_model                                                   |
// | 16-bit SDR SDRAM responder: bank tracking, CL read pipeline,       |
// | masked writes and protocol/timing violation reporting.             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sdram_chip_model #(
    parameter int ADDR_W = 16,
    parameter int TRCD   = 2,
    parameter int TRP    = 2
) (
    input  wire                clk,
    input  wire                init,
    sdram_chip_model_if.slave  bus,
    inout  wire  [15:0]        SDRAM_DQ,
    output wire                ready,
    output wire                err,
    output wire  [2:0]         err_code,
    output wire  [15:0]        refresh_cnt
);

    localparam int               c_TMR_W    = 4;
    localparam logic [c_TMR_W-1:0] c_TRCD_LD = c_TMR_W'(TRCD - 1);
    localparam logic [c_TMR_W-1:0] c_TRP_LD  = c_TMR_W'(TRP - 1);

    localparam logic [3:0] c_CMD_ACTIVE = 4'b0011;
    localparam logic [3:0] c_CMD_READ   = 4'b0101;
    localparam logic [3:0] c_CMD_WRITE  = 4'b0100;
    localparam logic [3:0] c_CMD_PRE    = 4'b0010;
    localparam logic [3:0] c_CMD_REF    = 4'b0001;
    localparam logic [3:0] c_CMD_LMR    = 4'b0000;
    localparam logic [3:0] c_CMD_NOP    = 4'b1111;

    typedef enum logic [0:0] {
        BANK_IDLE = 1'b0,
        BANK_OPEN = 1'b1
    } bank_state_t;

    bank_state_t        r_bank_state [4];
    bank_state_t        w_bank_nxt   [4];
    logic [12:0]        r_bank_row   [4];
    logic [12:0]        w_row_nxt    [4];
    logic [c_TMR_W-1:0] r_bank_tmr   [4];
    logic [c_TMR_W-1:0] w_tmr_nxt    [4];

    logic        r_ready;
    logic        r_cl3;
    logic        r_err;
    logic [2:0]  r_err_code;
    logic [15:0] r_refresh_cnt;
    logic [1:0]  r_pipe_vld;
    logic [15:0] r_pipe_dat [2];
    logic        r_dq_oe;
    logic [15:0] r_dq;

    logic [15:0] r_mem [0:(1<<ADDR_W)-1];

    wire [3:0]  w_cmd = bus.SDRAM_CKE ?
                        {bus.SDRAM_nCS, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} : c_CMD_NOP;
    wire [1:0]  w_ba  = bus.SDRAM_BA;
    wire        w_a10 = bus.SDRAM_A[10];
    wire        w_is_act = (w_cmd == c_CMD_ACTIVE);
    wire        w_is_rd  = (w_cmd == c_CMD_READ);
    wire        w_is_wr  = (w_cmd == c_CMD_WRITE);
    wire        w_is_pre = (w_cmd == c_CMD_PRE);
    wire        w_is_ref = (w_cmd == c_CMD_REF);
    wire        w_is_lmr = (w_cmd == c_CMD_LMR);

    wire        w_sel_open = (r_bank_state[w_ba] == BANK_OPEN);
    wire        w_sel_busy = (r_bank_tmr[w_ba] != '0);
    wire        w_any_open = (r_bank_state[0] == BANK_OPEN) || (r_bank_state[1] == BANK_OPEN) ||
                             (r_bank_state[2] == BANK_OPEN) || (r_bank_state[3] == BANK_OPEN);
    wire        w_mode_ok  = ((bus.SDRAM_A[6:4] == 3'd2) || (bus.SDRAM_A[6:4] == 3'd3)) &&
                             (bus.SDRAM_A[2:0] == 3'd0);

    // Store index drops the upper bits of {BA,row,col} when ADDR_W is narrower.
    wire [23:0]       w_full_addr = {w_ba, r_bank_row[w_ba], bus.SDRAM_A[8:0]};
    wire [ADDR_W-1:0] w_idx       = w_full_addr[ADDR_W-1:0];
    wire              w_unused    = ^w_full_addr;

    logic [2:0] w_viol;
    wire        w_ok = (w_viol == 3'd0);

    // Checks are ordered by code so the lowest applicable code is reported.
    always_comb begin
        w_viol = 3'd0;
        if (w_is_act) begin
            if (w_sel_open)      w_viol = 3'd1;
            else if (w_sel_busy) w_viol = 3'd2;
            else if (!r_ready)   w_viol = 3'd4;
        end else if (w_is_rd || w_is_wr) begin
            if (!w_sel_open)           w_viol = 3'd1;
            else if (w_sel_busy)       w_viol = 3'd2;
            else if (!r_ready)         w_viol = 3'd4;
            else if (w_is_wr && r_dq_oe) w_viol = 3'd5;
        end else if (w_is_ref) begin
            if (w_any_open) w_viol = 3'd1;
        end else if (w_is_lmr) begin
            if (w_any_open)      w_viol = 3'd1;
            else if (!w_mode_ok) w_viol = 3'd3;
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            w_bank_nxt[b] = r_bank_state[b];
            w_row_nxt[b]  = r_bank_row[b];
            w_tmr_nxt[b]  = (r_bank_tmr[b] != '0) ? r_bank_tmr[b] - 1'b1 : '0;
            if (w_ok) begin
                if (w_is_act && (w_ba == 2'(b))) begin
                    w_bank_nxt[b] = BANK_OPEN;
                    w_row_nxt[b]  = bus.SDRAM_A;
                    w_tmr_nxt[b]  = c_TRCD_LD;
                end
                if ((w_is_pre && (w_a10 || (w_ba == 2'(b)))) ||
                    ((w_is_rd || w_is_wr) && w_a10 && (w_ba == 2'(b)))) begin
                    w_bank_nxt[b] = BANK_IDLE;
                    w_tmr_nxt[b]  = c_TRP_LD;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            for (int b = 0; b < 4; b++) begin
                r_bank_state[b] <= BANK_IDLE;
                r_bank_row[b]   <= '0;
                r_bank_tmr[b]   <= '0;
            end
            r_ready       <= 1'b0;
            r_cl3         <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= 3'd0;
            r_refresh_cnt <= 16'd0;
            r_pipe_vld    <= 2'b00;
            r_pipe_dat[0] <= 16'd0;
            r_pipe_dat[1] <= 16'd0;
            r_dq_oe       <= 1'b0;
            r_dq          <= 16'd0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                r_bank_state[b] <= w_bank_nxt[b];
                r_bank_row[b]   <= w_row_nxt[b];
                r_bank_tmr[b]   <= w_tmr_nxt[b];
            end
            if (w_ok && w_is_lmr) begin
                r_ready <= 1'b1;
                r_cl3   <= (bus.SDRAM_A[6:4] == 3'd3);
            end
            if (w_ok && w_is_ref) begin
                r_refresh_cnt <= r_refresh_cnt + 16'd1;
            end
            if ((w_viol != 3'd0) && !r_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_viol;
            end
            // Stage 1 feeds stage 0, stage 0 feeds the pin driver; CL=3 enters one stage earlier.
            r_dq_oe       <= r_pipe_vld[0];
            r_dq          <= r_pipe_dat[0];
            r_pipe_vld[0] <= r_pipe_vld[1];
            r_pipe_dat[0] <= r_pipe_dat[1];
            r_pipe_vld[1] <= 1'b0;
            if (w_ok && w_is_rd) begin
                if (r_cl3) begin
                    r_pipe_vld[1] <= 1'b1;
                    r_pipe_dat[1] <= r_mem[w_idx];
                end else begin
                    r_pipe_vld[0] <= 1'b1;
                    r_pipe_dat[0] <= r_mem[w_idx];
                end
            end
        end
    end

    // The word store survives init.
    always_ff @(posedge clk) begin
        if (w_ok && w_is_wr && !init) begin
            if (!bus.SDRAM_DQML) r_mem[w_idx][7:0]  <= SDRAM_DQ[7:0];
            if (!bus.SDRAM_DQMH) r_mem[w_idx][15:8] <= SDRAM_DQ[15:8];
        end
    end

    assign SDRAM_DQ    = r_dq_oe ? r_dq : 16'hzzzz;
    assign ready       = r_ready;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign refresh_cnt = r_refresh_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sdram_chip_model.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sdram_chip_model                                                |
// | Directed self-checking bench; a released DQ bus reads as 16'hFFFF. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_sdram_chip_model;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam logic [15:0] DQ_Z   = 16'hFFFF;

    logic        clk = 1'b0;
    logic        init = 1'b1;
    logic        tb_dq_en = 1'b0;
    logic [15:0] tb_dq = 16'd0;
    wire  [15:0] SDRAM_DQ;
    wire         ready;
    wire         err;
    wire  [2:0]  err_code;
    wire  [15:0] refresh_cnt;
    int          checks = 0;
    int          errors = 0;

    sdram_chip_model_if bus_if ();

    sdram_chip_model dut (
        .clk         (clk),
        .init        (init),
        .bus         (bus_if),
        .SDRAM_DQ    (SDRAM_DQ),
        .ready       (ready),
        .err         (err),
        .err_code    (err_code),
        .refresh_cnt (refresh_cnt)
    );

    assign SDRAM_DQ = tb_dq_en ? tb_dq : 16'hzzzz;
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (SDRAM_DQ[g]);
    end

    always #5 clk = ~clk;

    // Command is presented for exactly one rising edge; returns on the following falling edge.
    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [1:0] dqm, input logic drv, input logic [15:0] d);
        {bus_if.SDRAM_nCS, bus_if.SDRAM_nRAS, bus_if.SDRAM_nCAS, bus_if.SDRAM_nWE} = c;
        bus_if.SDRAM_BA = ba;
        bus_if.SDRAM_A  = a;
        {bus_if.SDRAM_DQMH, bus_if.SDRAM_DQML} = dqm;
        tb_dq_en = drv;
        tb_dq    = d;
        @(negedge clk);
        {bus_if.SDRAM_nCS, bus_if.SDRAM_nRAS, bus_if.SDRAM_nCAS, bus_if.SDRAM_nWE} = CMD_NOP;
        {bus_if.SDRAM_DQMH, bus_if.SDRAM_DQML} = 2'b00;
        tb_dq_en = 1'b0;
    endtask

    task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a);
        issue(c, ba, a, 2'b00, 1'b0, 16'd0);
    endtask

    task automatic nop(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        init = 1'b1;
        nop(2);
        init = 1'b0;
        nop(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", err_code); end
        checks++; if (refresh_cnt !== 16'd0) begin errors++; $display("FAIL reset_refresh: got %0d want 0", refresh_cnt); end
        checks++; if (SDRAM_DQ !== DQ_Z) begin errors++; $display("FAIL reset_dq: got %h want released", SDRAM_DQ); end
    endtask

    task automatic test_not_ready();
        do_reset();
        cmd(CMD_ACT, 2'd0, 13'h001);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL early_act_err: got %b want 1", err); end
        checks++; if (err_code !== 3'd4) begin errors++; $display("FAIL early_act_code: got %0d want 4", err_code); end
        cmd(CMD_LMR, 2'd0, 13'h021);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bad_mode_ready: got %b want 0", ready); end
        checks++; if (err_code !== 3'd4) begin errors++; $display("FAIL bad_mode_code: got %0d want 4", err_code); end
    endtask

    task automatic test_init_seq();
        do_reset();
        cmd(CMD_PRE, 2'd0, 13'h400);
        repeat (8) cmd(CMD_REF, 2'd0, 13'h000);
        cmd(CMD_LMR, 2'd0, 13'h220);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL init_ready: got %b want 1", ready); end
        checks++; if (refresh_cnt !== 16'd8) begin errors++; $display("FAIL init_refresh: got %0d want 8", refresh_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL init_err: got %b want 0", err); end
    endtask

    task automatic test_masked_write();
        cmd(CMD_ACT, 2'd1, 13'h012);
        nop(1);
        issue(CMD_WR, 2'd1, 13'h005, 2'b00, 1'b1, 16'h0000);
        issue(CMD_WR, 2'd1, 13'h405, 2'b10, 1'b1, 16'hA55A);
        nop(1);
        cmd(CMD_ACT, 2'd1, 13'h012);
        nop(1);
        cmd(CMD_RD, 2'd1, 13'h005);
        checks++; if (SDRAM_DQ !== DQ_Z) begin errors++; $display("FAIL mw_early: got %h want released", SDRAM_DQ); end
        nop(1);
        checks++; if (SDRAM_DQ !== 16'h005A) begin errors++; $display("FAIL mw_data: got %h want 005a", SDRAM_DQ); end
        nop(1);
        checks++; if (SDRAM_DQ !== DQ_Z) begin errors++; $display("FAIL mw_release: got %h want released", SDRAM_DQ); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mw_err: got %b want 0", err); end
    endtask

    task automatic test_back_to_back();
        cmd(CMD_PRE, 2'd0, 13'h400);
        nop(1);
        cmd(CMD_LMR, 2'd0, 13'h230);
        cmd(CMD_ACT, 2'd0, 13'h001);
        cmd(CMD_ACT, 2'd2, 13'h003);
        issue(CMD_WR, 2'd0, 13'h010, 2'b00, 1'b1, 16'h1234);
        issue(CMD_WR, 2'd2, 13'h011, 2'b00, 1'b1, 16'hBEEF);
        cmd(CMD_RD, 2'd0, 13'h010);
        cmd(CMD_RD, 2'd2, 13'h011);
        checks++; if (SDRAM_DQ !== DQ_Z) begin errors++; $display("FAIL b2b_early: got %h want released", SDRAM_DQ); end
        nop(1);
        checks++; if (SDRAM_DQ !== 16'h1234) begin errors++; $display("FAIL b2b_first: got %h want 1234", SDRAM_DQ); end
        nop(1);
        checks++; if (SDRAM_DQ !== 16'hBEEF) begin errors++; $display("FAIL b2b_second: got %h want beef", SDRAM_DQ); end
        nop(1);
        checks++; if (SDRAM_DQ !== DQ_Z) begin errors++; $display("FAIL b2b_release: got %h want released", SDRAM_DQ); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", err); end
    endtask

    task automatic test_timing_violation();
        cmd(CMD_ACT, 2'd3, 13'h005);
        cmd(CMD_RD, 2'd3, 13'h000);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL trcd_err: got %b want 1", err); end
        checks++; if (err_code !== 3'd2) begin errors++; $display("FAIL trcd_code: got %0d want 2", err_code); end
        nop(2);
        checks++; if (SDRAM_DQ !== DQ_Z) begin errors++; $display("FAIL trcd_dq_a: got %h want released", SDRAM_DQ); end
        nop(1);
        checks++; if (SDRAM_DQ !== DQ_Z) begin errors++; $display("FAIL trcd_dq_b: got %h want released", SDRAM_DQ); end
        cmd(CMD_ACT, 2'd3, 13'h006);
        checks++; if (err_code !== 3'd2) begin errors++; $display("FAIL sticky_code: got %0d want 2", err_code); end
    endtask

    task automatic test_init_midread();
        do_reset();
        cmd(CMD_LMR, 2'd0, 13'h220);
        cmd(CMD_REF, 2'd0, 13'h000);
        cmd(CMD_REF, 2'd0, 13'h000);
        cmd(CMD_ACT, 2'd0, 13'h001);
        nop(1);
        cmd(CMD_RD, 2'd0, 13'h010);
        @(posedge clk);
        #2;
        checks++; if (SDRAM_DQ !== 16'h1234) begin errors++; $display("FAIL mid_driven: got %h want 1234", SDRAM_DQ); end
        init = 1'b1;
        #1;
        checks++; if (SDRAM_DQ !== DQ_Z) begin errors++; $display("FAIL mid_dq_z: got %h want released", SDRAM_DQ); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", ready); end
        checks++; if (refresh_cnt !== 16'd0) begin errors++; $display("FAIL mid_refresh: got %0d want 0", refresh_cnt); end
        @(negedge clk);
        nop(1);
        init = 1'b0;
        nop(1);
        cmd(CMD_LMR, 2'd0, 13'h220);
        cmd(CMD_ACT, 2'd0, 13'h001);
        nop(1);
        cmd(CMD_RD, 2'd0, 13'h010);
        nop(1);
        checks++; if (SDRAM_DQ !== 16'h1234) begin errors++; $display("FAIL keep_store: got %h want 1234", SDRAM_DQ); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL keep_err: got %b want 0", err); end
    endtask

    initial begin
        bus_if.SDRAM_CKE = 1'b1;
        {bus_if.SDRAM_nCS, bus_if.SDRAM_nRAS, bus_if.SDRAM_nCAS, bus_if.SDRAM_nWE} = CMD_NOP;
        bus_if.SDRAM_BA   = 2'd0;
        bus_if.SDRAM_A    = 13'd0;
        bus_if.SDRAM_DQML = 1'b0;
        bus_if.SDRAM_DQMH = 1'b0;
        @(negedge clk);
        test_reset();
        test_not_ready();
        test_init_seq();
        test_masked_write();
        test_back_to_back();
        test_timing_violation();
        test_init_midread();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
